// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and condition constants, FSM states and flag indices for alu_seq_ctrl
package alu_seq_pkg;
    localparam int MEM_TIMEOUT = 255;
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_OR = 4'h3,
                           OP_AND = 4'h4, OP_XOR = 4'h5, OP_MOVI = 4'h6, OP_MOV = 4'h7,
                           OP_CMP = 4'hB, OP_LDR = 4'hD, OP_STR = 4'hE;
    localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
                           CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
                           CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
                           CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF;
    localparam int FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MOV || op == OP_CMP || op == OP_LDR || op == OP_STR;
    endfunction
    function automatic logic op_writes(input logic [3:0] op);
        return op <= OP_MOV || op == OP_LDR;
    endfunction
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: instruction handshake and data-memory port of the ALU sequencer
interface alu_seq_ctrl_if;
    logic        instr_valid, instr_ready;
    logic [31:0] instr;
    logic        mem_req, mem_we, mem_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    modport master (input instr_valid, instr, mem_rdata, mem_ready,
                    output instr_ready, mem_req, mem_we, mem_addr, mem_wdata);
    modport slave  (output instr_valid, instr, mem_rdata, mem_ready,
                    input instr_ready, mem_req, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/alu_seq_cond.sv
// alu_seq_cond: evaluates a 4-bit condition code against the NZCV flags
module alu_seq_cond
    import alu_seq_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];
    always_comb begin
        case (cond)
            CC_EQ:   pass = z;
            CC_NE:   pass = !z;
            CC_CS:   pass = c;
            CC_CC:   pass = !c;
            CC_MI:   pass = n;
            CC_PL:   pass = !n;
            CC_VS:   pass = v;
            CC_VC:   pass = !v;
            CC_HI:   pass = c && !z;
            CC_LS:   pass = !c || z;
            CC_GE:   pass = n == v;
            CC_LT:   pass = n != v;
            CC_GT:   pass = !z && (n == v);
            CC_LE:   pass = z || (n != v);
            CC_AL:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer driving the ALU, register file and data memory.
// Define ALU_SEQ_MEM_TIMEOUT_EN to abandon memory requests after MEM_TIMEOUT wait cycles.
module alu_seq_ctrl
    import alu_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_ctrl_if.master bus,
    output logic [3:0]     rf_ra_addr,
    output logic [3:0]     rf_rb_addr,
    input  logic [31:0]    rf_ra_data,
    input  logic [31:0]    rf_rb_data,
    output logic [31:0]    alu_a,
    output logic [31:0]    alu_b,
    output logic [3:0]     alu_opcode,
    output logic [2:0]     alu_sr_cont,
    output logic [4:0]     alu_sr_bit,
    output logic [15:0]    alu_imm,
    input  logic [31:0]    alu_result,
    input  logic [3:0]     alu_flags,
    output logic           rf_we,
    output logic [3:0]     rf_wa,
    output logic [31:0]    rf_wd,
    output logic [3:0]     flags,
    output logic           busy,
    output logic           illegal,
    output logic           mem_err
);
    state_t      state, next;
    logic [31:0] ir, wb_data;
    logic [3:0]  wb_flags, op, rd;
    logic        pass, tmo;

    assign op = ir[27:24];
    assign rd = ir[19:16];

    alu_seq_cond u_cond (.cond(ir[31:28]), .flags(flags), .pass(pass));

`ifdef ALU_SEQ_MEM_TIMEOUT_EN
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= (state == MEM) ? cnt + 8'd1 : '0;
    assign tmo = (state == MEM) && (cnt == 8'(MEM_TIMEOUT));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        next    = state;
        illegal = 1'b0;
        case (state)
            IDLE:    next = bus.instr_valid ? DECODE : IDLE;
            DECODE:  next = EXEC;
            EXEC: begin
                illegal = !op_legal(op);
                next    = (illegal || !pass) ? IDLE : (op == OP_LDR || op == OP_STR) ? MEM : WB;
            end
            MEM:     next = tmo ? IDLE : !bus.mem_ready ? MEM : (op == OP_LDR) ? WB : IDLE;
            WB:      next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ir       <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            wb_data  <= '0;
            wb_flags <= '0;
            flags    <= '0;
        end else begin
            state <= next;
            if (state == IDLE && bus.instr_valid) ir <= bus.instr;
            if (state == DECODE) begin
                alu_a <= rf_ra_data;
                alu_b <= rf_rb_data;
            end
            if (state == EXEC) begin
                wb_data  <= (op == OP_MOVI) ? {16'h0, ir[15:0]} : alu_result;
                wb_flags <= alu_flags;
            end
            if (state == MEM && bus.mem_ready) wb_data <= bus.mem_rdata;
            // CMP always updates flags; ALU ops only when S is set
            if (state == WB && (op == OP_CMP || (ir[23] && op <= OP_XOR))) flags <= wb_flags;
        end
    end

    assign bus.instr_ready = state == IDLE;
    assign busy            = state != IDLE;
    assign rf_ra_addr      = (state == DECODE) ? ir[15:12] : '0;
    assign rf_rb_addr      = (state == DECODE) ? ((op == OP_STR) ? rd : ir[11:8]) : '0;
    assign alu_opcode      = (state == EXEC) ? op : '0;
    assign alu_sr_cont     = (state == EXEC) ? ir[22:20] : '0;
    assign alu_sr_bit      = (state == EXEC) ? ir[7:3] : '0;
    assign alu_imm         = (state == EXEC) ? ir[15:0] : '0;
    assign rf_we           = (state == WB) && op_writes(op);
    assign rf_wa           = rf_we ? rd : '0;
    assign rf_wd           = rf_we ? wb_data : '0;
    assign bus.mem_req     = (state == MEM) && !tmo;
    assign bus.mem_we      = bus.mem_req && (op == OP_STR);
    assign bus.mem_addr    = bus.mem_req ? alu_a[15:0] : '0;
    assign bus.mem_wdata   = bus.mem_we ? alu_b : '0;
    assign mem_err         = tmo;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench with an architectural reference model of the sequencer
module tb_alu_seq_ctrl;
    localparam logic [1:0] EV_WR = 2'd0, EV_MEM = 2'd1, EV_ILL = 2'd2, EV_ERR = 2'd3;
    typedef struct packed {
        logic [1:0]  k;
        logic        we;
        logic [15:0] a;
        logic [31:0] d;
    } ev_t;

    logic clk = 1'b0, rst_n;
    logic [3:0]  rf_ra_addr, rf_rb_addr, alu_opcode, alu_flags, rf_wa, flags;
    logic [31:0] rf_ra_data, rf_rb_data, alu_a, alu_b, alu_result, rf_wd;
    logic [2:0]  alu_sr_cont;
    logic [4:0]  alu_sr_bit;
    logic [15:0] alu_imm;
    logic        rf_we, busy, illegal, mem_err;

    alu_seq_ctrl_if bus();

    alu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_sr_cont(alu_sr_cont), .alu_sr_bit(alu_sr_bit), .alu_imm(alu_imm),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .flags(flags),
        .busy(busy), .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int mwait = 0;
    ev_t exp_q[$];
    logic [31:0] rf [16];
    logic [31:0] mrf [16];
    logic [3:0]  mflags;
    logic [31:0] dmem [logic [15:0]];
    logic [31:0] mdm [logic [15:0]];

    function automatic logic [31:0] init_val(input int i);
        return 32'h9E3779B9 * (i + 1);
    endfunction
    function automatic logic [31:0] dflt(input logic [15:0] a);
        return {16'hA5A5, a};
    endfunction
    function automatic ev_t mk(input logic [1:0] k, input logic we, input logic [15:0] a, input logic [31:0] d);
        return '{k, we, a, d};
    endfunction
    // Returns {N,Z,C,V, result}; C is "no borrow" for subtraction
    function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b,
                                            input logic [2:0] sc, input logic [4:0] sh);
        logic [32:0] t;
        logic [31:0] bs, r;
        logic c, v;
        bs = (sc == 3'd1) ? b << sh : (sc == 3'd2) ? b >> sh : b;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            4'h0: begin t = {1'b0, a} + {1'b0, bs}; r = t[31:0]; c = t[32]; v = (a[31] == bs[31]) && (r[31] != a[31]); end
            4'h1, 4'hB: begin r = a - bs; c = a >= bs; v = (a[31] != bs[31]) && (r[31] != a[31]); end
            4'h2: r = a * bs;
            4'h3: r = a | bs;
            4'h4: r = a & bs;
            4'h5: r = a ^ bs;
            4'h7: r = bs;
            default: r = '0;
        endcase
        return {r[31], r == 32'h0, c, v, r};
    endfunction
    function automatic bit cond_ok(input logic [3:0] cd, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cd)
            0: return z;       1: return !z;
            2: return c;       3: return !c;
            4: return n;       5: return !n;
            6: return v;       7: return !v;
            8: return c && !z; 9: return !c || z;
            10: return n == v; 11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    function automatic bit legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB, 4'hD, 4'hE};
    endfunction
    function automatic logic [31:0] mkins(input logic [3:0] cd, op, input logic s, input logic [2:0] sc,
                                          input logic [3:0] rd, rn, rm, input logic [4:0] sh);
        return {cd, op, s, sc, rd, rn, rm, sh, 3'b000};
    endfunction

    // environment: ALU, register file and data memory
    always_comb {alu_flags, alu_result} = alu_ref(alu_opcode, alu_a, alu_b, alu_sr_cont, alu_sr_bit);
    assign rf_ra_data = rf[rf_ra_addr];
    assign rf_rb_data = rf[rf_rb_addr];
    initial begin
        for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
        forever begin
            @(posedge clk);
            if (rf_we) rf[rf_wa] <= rf_wd;
        end
    end
    initial begin
        int rcnt;
        rcnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (bus.mem_req) begin
                if (rcnt == mwait) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = dmem.exists(bus.mem_addr) ? dmem[bus.mem_addr] : dflt(bus.mem_addr);
                    if (bus.mem_we) dmem[bus.mem_addr] = bus.mem_wdata;
                end
                rcnt++;
            end else rcnt = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic ev_chk(input ev_t got);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected event: kind=%0d we=%b a=%h d=%h", got.k, got.we, got.a, got.d);
        end else begin
            e = exp_q.pop_front();
            if (e !== got) begin
                bad++;
                $display("FAIL event: got kind=%0d we=%b a=%h d=%h expected kind=%0d we=%b a=%h d=%h",
                         got.k, got.we, got.a, got.d, e.k, e.we, e.a, e.d);
            end
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a write, request, illegal or error
    initial begin
        ev_t cur, first;
        logic prev;
        prev = 1'b0;
        first = '0;
        forever begin
            @(negedge clk);
            cur = mk(EV_MEM, bus.mem_we, bus.mem_addr, bus.mem_wdata);
            if (bus.mem_req && !prev) begin
                ev_chk(cur);
                first = cur;
            end else if (bus.mem_req) begin
                total++;
                if (cur !== first) begin
                    bad++;
                    $display("FAIL mem_hold: got we=%b a=%h d=%h expected we=%b a=%h d=%h",
                             cur.we, cur.a, cur.d, first.we, first.a, first.d);
                end
            end
            if (rf_we) ev_chk(mk(EV_WR, 1'b0, {12'h0, rf_wa}, rf_wd));
            if (illegal) ev_chk(mk(EV_ILL, 1'b0, '0, '0));
            if (mem_err) ev_chk(mk(EV_ERR, 1'b0, '0, '0));
            prev = bus.mem_req;
        end
    end

    task automatic model(input logic [31:0] ins, input int w, output int lat);
        logic [3:0] op, rd;
        logic [31:0] a, b, v;
        logic [35:0] r;
        logic [15:0] ad;
        op = ins[27:24];
        rd = ins[19:16];
        a = mrf[ins[15:12]];
        b = mrf[(op == 4'hE) ? rd : ins[11:8]];
        r = alu_ref(op, a, b, ins[22:20], ins[7:3]);
        ad = a[15:0];
        lat = 4;
        if (!legal(op)) begin
            exp_q.push_back(mk(EV_ILL, 1'b0, '0, '0));
            lat = 3;
        end else if (!cond_ok(ins[31:28], mflags)) lat = 3;
        else if (op == 4'hD) begin
            v = mdm.exists(ad) ? mdm[ad] : dflt(ad);
            exp_q.push_back(mk(EV_MEM, 1'b0, ad, '0));
            exp_q.push_back(mk(EV_WR, 1'b0, {12'h0, rd}, v));
            mrf[rd] = v;
            lat = 5 + w;
        end else if (op == 4'hE) begin
            exp_q.push_back(mk(EV_MEM, 1'b1, ad, b));
            mdm[ad] = b;
            lat = 4 + w;
        end else if (op == 4'hB) mflags = r[35:32];
        else begin
            v = (op == 4'h6) ? {16'h0, ins[15:0]} : r[31:0];
            exp_q.push_back(mk(EV_WR, 1'b0, {12'h0, rd}, v));
            mrf[rd] = v;
            if (ins[23] && op <= 4'h5) mflags = r[35:32];
        end
    endtask

    task automatic hs(input logic [31:0] ins);
        int n;
        n = 0;
        while (!bus.instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic run(input logic [31:0] ins, input int w);
        int lat, exp_lat;
        mwait = w;
        model(ins, w, exp_lat);
        hs(ins);
        chk("rd_addr", {24'h0, rf_ra_addr, rf_rb_addr},
            {24'h0, ins[15:12], (ins[27:24] == 4'hE) ? ins[19:16] : ins[11:8]});
        @(negedge clk);
        chk("alu_ctl", {4'h0, alu_opcode, alu_sr_cont, alu_sr_bit, alu_imm},
            {4'h0, ins[27:24], ins[22:20], ins[7:3], ins[15:0]});
        lat = 2;
        while (!bus.instr_ready && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("flags", {28'h0, flags}, {28'h0, mflags});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] legal_ops [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB, 4'hD, 4'hE};
        logic [31:0] ins;
        int k, n;
        for (int i = 0; i < 16; i++) mrf[i] = init_val(i);
        mflags = 4'h0;
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, bus.instr_ready}, 32'd1);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_flags", {28'h0, flags}, 32'd0);
        chk("rst_outs", {28'h0, rf_we, bus.mem_req, illegal, mem_err}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run({4'hE, 4'h6, 4'h0, 4'd1, 16'd5}, 0);
        run({4'hE, 4'h6, 4'h0, 4'd2, 16'd7}, 0);
        run(mkins(4'hE, 4'h0, 1'b1, 3'd0, 4'd3, 4'd1, 4'd2, 5'd0), 0);
        chk("add_r3", rf[3], 32'd12);
        chk("add_flags", {28'h0, flags}, 32'd0);
        run(mkins(4'hE, 4'hB, 1'b0, 3'd0, 4'd0, 4'd1, 4'd1, 5'd0), 0);
        chk("cmp_z", {31'h0, flags[2]}, 32'd1);
        run(mkins(4'h1, 4'h0, 1'b1, 3'd0, 4'd3, 4'd1, 4'd2, 5'd0), 0);
        run({4'hE, 4'h6, 4'h0, 4'd4, 16'hBEEF}, 0);
        chk("movi_r4", rf[4], 32'h0000BEEF);
        run({4'hE, 4'h6, 4'h0, 4'd1, 16'h0010}, 0);
        run(mkins(4'hE, 4'hE, 1'b0, 3'd0, 4'd2, 4'd1, 4'd0, 5'd0), 3);
        run(mkins(4'hE, 4'hD, 1'b0, 3'd0, 4'd5, 4'd1, 4'd0, 5'd0), 0);
        chk("ldr_r5", rf[5], 32'd7);
        run(mkins(4'hE, 4'h9, 1'b0, 3'd0, 4'd6, 4'd1, 4'd2, 5'd0), 0);

        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            k = $urandom_range(0, 13);
            ins[27:24] = (k < 11) ? legal_ops[k] : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0 || !legal(ins[27:24])) ins[31:28] = 4'hE;
            run(ins, $urandom_range(0, 4));
        end

        // reset while a load is waiting on memory
        mwait = 100000;
        ins = mkins(4'hE, 4'hD, 1'b0, 3'd0, 4'd6, 4'd1, 4'd0, 5'd0);
        exp_q.push_back(mk(EV_MEM, 1'b0, mrf[1][15:0], '0));
        hs(ins);
        n = 0;
        while (!bus.mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mid_mem_req", {31'h0, bus.mem_req}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'd0);
        chk("rst_mid_ready", {30'h0, bus.instr_ready, busy}, 32'd2);
        chk("rst_mid_flags", {28'h0, flags}, 32'd0);
        mflags = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef ALU_SEQ_MEM_TIMEOUT_EN
        begin
            int lat;
            mwait = 100000;
            exp_q.push_back(mk(EV_MEM, 1'b0, mrf[1][15:0], '0));
            exp_q.push_back(mk(EV_ERR, 1'b0, '0, '0));
            hs(ins);
            lat = 1;
            while (!bus.instr_ready && lat < 600) begin
                @(negedge clk);
                lat++;
            end
            chk("timeout_latency", lat, 32'd259);
        end
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
